// File: rtl/mux_pkg.sv
// Shared constants and mode encodings for the channel-select / auto-scan pipeline.
package mux_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 16;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Select width: ceil(log2(channels)), never below one bit.
  function automatic int unsigned sel_width(input int unsigned channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Auto-scan channel counter: synchronous clear has priority, advance wraps at CHANNELS-1.
module mux_scan_ctr #(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned SEL_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [SEL_W-1:0] idx
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (adv) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/mux_scan_pipe.sv
// Channel mux with direct-select or auto-scan addressing and a single-entry
// valid/ready output register.
module mux_scan_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  localparam int unsigned SEL_W   = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      scan_wrap,
  output logic                      sel_err
);

  localparam int unsigned     SEL_SPAN = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  logic             accept;
  logic             scan_mode;
  logic [SEL_W-1:0] scan_idx;
  logic [SEL_W-1:0] ch_idx;
  logic [WIDTH-1:0] ch_data;
  logic [SEL_SPAN-1:0] in_range;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  assign scan_mode = (mode_e'(mode) == MODE_SCAN);
  assign in_ready  = en & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;

  mux_scan_ctr #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_scan_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~scan_mode),
    .adv   (accept),
    .idx   (scan_idx)
  );

  // Table of legal select codes; codes past CHANNELS-1 read as zero data.
  always_comb begin
    in_range = '0;
    for (int unsigned i = 0; i < SEL_SPAN; i++) begin
      in_range[i] = (i < CHANNELS);
    end
  end

  always_comb begin
    ch_idx  = scan_mode ? scan_idx : sel;
    ch_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch_idx == SEL_W'(k)) begin
        ch_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    dout_d      = dout_q;
    out_ch_d    = out_ch_q;
    wrap_d      = wrap_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      dout_d      = ch_data;
      out_ch_d    = ch_idx;
      wrap_d      = scan_mode & (scan_idx == LAST_IDX);
      err_d       = ~scan_mode & ~in_range[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_ch_q    <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_ch_q    <= out_ch_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_ch    = out_ch_q;
  assign scan_wrap = wrap_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_scan_pipe.sv
// Directed bench: a 16-channel instance for the main flows and a 12-channel
// instance for out-of-range select, both on a shared clock and reset.
module tb_mux_scan_pipe;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         mode;
  logic [3:0]   sel;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] din_a;
  logic [95:0]  din_b;

  logic         in_ready_a, out_valid_a, wrap_a, err_a;
  logic [7:0]   dout_a;
  logic [3:0]   out_ch_a;
  logic         in_ready_b, out_valid_b, wrap_b, err_b;
  logic [7:0]   dout_b;
  logic [3:0]   out_ch_b;

  int tests = 0;
  int fails = 0;

  mux_scan_pipe #(.WIDTH(8), .CHANNELS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din_a),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .dout(dout_a), .out_ch(out_ch_a),
    .scan_wrap(wrap_a), .sel_err(err_a)
  );

  mux_scan_pipe #(.WIDTH(8), .CHANNELS(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din_b),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .dout(dout_b), .out_ch(out_ch_b),
    .scan_wrap(wrap_b), .sel_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int base);
    for (int k = 0; k < 16; k++) din_a[k*8 +: 8] = 8'(base + k);
    for (int k = 0; k < 12; k++) din_b[k*8 +: 8] = 8'(8'h10 + k);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 4'd0;
    in_valid = 1'b0; out_ready = 1'b0;
    din_a = '0; din_b = '0;
    #1;
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_dout",  32'(dout_a),      32'd0);
    chk("rst_ch",    32'(out_ch_a),    32'd0);
    chk("rst_wrap",  32'(wrap_a),      32'd0);
    chk("rst_err",   32'(err_a),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Direct select of channel 5.
    set_din(8'hA0);
    en = 1'b1; mode = 1'b0; sel = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("dir_in_ready", 32'(in_ready_a), 32'd1);
    tick();
    chk("dir_valid", 32'(out_valid_a), 32'd1);
    chk("dir_dout",  32'(dout_a),      32'hA5);
    chk("dir_ch",    32'(out_ch_a),    32'd5);
    chk("dir_err",   32'(err_a),       32'd0);
    chk("dir_wrap",  32'(wrap_a),      32'd0);
    in_valid = 1'b0;
    tick();
    chk("dir_drained", 32'(out_valid_a), 32'd0);

    // Auto-scan, 17 back-to-back samples; the 17th wraps to channel 0.
    set_din(0);
    mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("scan_valid", 32'(out_valid_a), 32'd1);
      chk("scan_dout",  32'(dout_a),      32'(i % 16));
      chk("scan_ch",    32'(out_ch_a),    32'(i % 16));
      chk("scan_wrap",  32'(wrap_a),      32'((i % 16) == 15));
    end

    // Backpressure: ch0 held for 3 cycles, then consumed exactly once.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready_a), 32'd0);
      tick();
      chk("bp_valid", 32'(out_valid_a), 32'd1);
      chk("bp_dout",  32'(dout_a),      32'd0);
      chk("bp_ch",    32'(out_ch_a),    32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("bp_consumed", 32'(out_valid_a), 32'd0);
    in_valid = 1'b1;
    tick();
    chk("bp_next_dout", 32'(dout_a), 32'd1);
    chk("bp_next_ch",   32'(out_ch_a), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_next_drained", 32'(out_valid_a), 32'd0);

    // Enable gating: load ch2, then en=0 for 4 cycles; held sample drains.
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("en_load_dout", 32'(dout_a), 32'd2);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_ready = (i >= 2);
      #1;
      chk("en_in_ready", 32'(in_ready_a), 32'd0);
      tick();
      chk("en_valid", 32'(out_valid_a), 32'(i < 2));
      chk("en_dout",  32'(dout_a),      32'd2);
    end
    en = 1'b1;
    tick();
    chk("en_resume_dout", 32'(dout_a), 32'd3);
    chk("en_resume_ch",   32'(out_ch_a), 32'd3);

    // Out-of-range select on the 12-channel instance, plus boundaries.
    mode = 1'b0; sel = 4'd13;
    tick();
    chk("oob_valid", 32'(out_valid_b), 32'd1);
    chk("oob_dout",  32'(dout_b),      32'd0);
    chk("oob_ch",    32'(out_ch_b),    32'd13);
    chk("oob_err",   32'(err_b),       32'd1);
    chk("a13_dout",  32'(dout_a),      32'd13);
    chk("a13_err",   32'(err_a),       32'd0);
    sel = 4'd11;
    tick();
    chk("b11_dout", 32'(dout_b), 32'h1B);
    chk("b11_err",  32'(err_b),  32'd0);
    sel = 4'd12;
    tick();
    chk("b12_dout", 32'(dout_b), 32'd0);
    chk("b12_err",  32'(err_b),  32'd1);

    // Reset mid-scan: seven samples leave scan_idx at 7 with ch6 held.
    set_din(8'h40);
    mode = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_rst_dout",  32'(dout_a),      32'h46);
    chk("pre_rst_valid", 32'(out_valid_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_dout",  32'(dout_a),      32'd0);
    chk("mid_rst_ch",    32'(out_ch_a),    32'd0);
    chk("mid_rst_wrap",  32'(wrap_a),      32'd0);
    chk("mid_rst_err",   32'(err_b),       32'd0);
    #2;
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid_a), 32'd1);
    chk("post_rst_dout",  32'(dout_a),      32'h40);
    chk("post_rst_ch",    32'(out_ch_a),    32'd0);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
